// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with full-line, word-0-first refill.
// Optional macro ICACHE_FLUSH_EN adds a flush input that invalidates every line.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_data,
  output logic        icache_rdy,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data,
  input  logic        mem_rdy,
`ifdef ICACHE_FLUSH_EN
  input  logic        flush,
`endif
  output logic [1:0]  state_dbg
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TW = 30 - OB - IB;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] REFILL_REQ = 2'd1;
  localparam logic [1:0] REFILL_GAP = 2'd2;
  localparam logic [1:0] RESP       = 2'd3;

  // Handshakes: the CPU holds icache_req/icache_addr until the one-cycle
  // icache_rdy pulse; memory answers a held mem_req/mem_addr with mem_rdy,
  // and mem_rdy is only honoured in REFILL_REQ.
  logic [1:0]    state;
  logic [OB-1:0] wcnt;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tag_q [SETS];
  logic [31:0]   data_q [SETS][LINE_WORDS];

  logic [TW-1:0] lat_tag;
  logic [IB-1:0] lat_idx;
  logic [OB-1:0] lat_off;

  logic [OB-1:0] cur_off;
  logic [IB-1:0] cur_idx;
  logic [TW-1:0] cur_tag;
  logic          hit;
  logic          last_word;
  logic          unused_addr_bits;

  assign cur_off   = icache_addr[2+OB-1:2];
  assign cur_idx   = icache_addr[2+OB+IB-1:2+OB];
  assign cur_tag   = icache_addr[31:2+OB+IB];
  assign hit       = valid[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign last_word = (wcnt == OB'(LINE_WORDS - 1));
  assign state_dbg = state;
  assign unused_addr_bits = &{1'b0, icache_addr[1:0]};

  logic flush_in;
  logic flush_pend;
`ifdef ICACHE_FLUSH_EN
  assign flush_in = flush;
  // A flush seen mid-refill is held until the response has been issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_pend <= 1'b0;
    end else if (state == IDLE || state == RESP) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end
  end
`else
  assign flush_in   = 1'b0;
  assign flush_pend = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      valid       <= '0;
      icache_rdy  <= 1'b0;
      icache_data <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      lat_tag     <= '0;
      lat_idx     <= '0;
      lat_off     <= '0;
    end else begin
      icache_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_in) begin
            valid <= '0;
          end else if (icache_req && !icache_rdy) begin
            if (hit) begin
              icache_rdy  <= 1'b1;
              icache_data <= data_q[cur_idx][cur_off];
            end else begin
              valid[cur_idx] <= 1'b0;
              wcnt           <= '0;
              lat_tag        <= cur_tag;
              lat_idx        <= cur_idx;
              lat_off        <= cur_off;
              mem_req        <= 1'b1;
              mem_addr       <= {cur_tag, cur_idx, {OB{1'b0}}, 2'b00};
              state          <= REFILL_REQ;
            end
          end
        end
        REFILL_REQ: begin
          if (mem_rdy) begin
            mem_req <= 1'b0;
            if (last_word) begin
              valid[lat_idx] <= 1'b1;
              state          <= RESP;
            end else begin
              wcnt  <= wcnt + 1'b1;
              state <= REFILL_GAP;
            end
          end
        end
        REFILL_GAP: begin
          mem_req  <= 1'b1;
          mem_addr <= {lat_tag, lat_idx, wcnt, 2'b00};
          state    <= REFILL_REQ;
        end
        RESP: begin
          icache_rdy  <= 1'b1;
          icache_data <= data_q[lat_idx][lat_off];
          if (flush_pend || flush_in) valid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (state == REFILL_REQ && mem_rdy) begin
      data_q[lat_idx][wcnt] <= mem_data;
      if (last_word) tag_q[lat_idx] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches
// against a line-residency model; flush scenarios build when ICACHE_FLUSH_EN is set.
module tb_icache_dm;

  localparam int LW   = 4;
  localparam int SETS = 16;

  logic        clock;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data;
  logic        mem_rdy;
  logic [1:0]  state_dbg;
`ifdef ICACHE_FLUSH_EN
  logic        flush;
`endif

  icache_dm #(.LINE_WORDS(LW), .SETS(SETS)) dut (
    .clock(clock), .reset(reset),
    .icache_addr(icache_addr), .icache_req(icache_req),
    .icache_data(icache_data), .icache_rdy(icache_rdy),
    .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_data(mem_data), .mem_rdy(mem_rdy),
`ifdef ICACHE_FLUSH_EN
    .flush(flush),
`endif
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rdy_viol = 0;
  int mem_lat = 2;
  bit directed = 1'b1;
  bit noise_en = 1'b0;
  logic [31:0] req_log[$];
  logic [31:0] exp_q[$];
  int unsigned model_line[int unsigned];

  // clock / reset / free-running cycle counter
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  initial begin : rdy_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (icache_rdy && prev) rdy_viol++;
      prev = icache_rdy;
    end
  end

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    if (directed) return 32'hA0 + ((a >> 2) % LW);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F1E;
  endfunction

  function automatic int unsigned line_of(logic [31:0] a);
    return a / (LW * 4);
  endfunction

  function automatic bit model_hit(logic [31:0] a);
    int unsigned ln;
    ln = line_of(a);
    return model_line.exists(ln % SETS) && (model_line[ln % SETS] == ln);
  endfunction

  function automatic void model_fill(logic [31:0] a);
    model_line[line_of(a) % SETS] = line_of(a);
  endfunction

  function automatic int miss_lat(int l);
    return LW * l + (LW - 1) + 2;
  endfunction

  // memory responder: answers on the mem_lat-th cycle of each mem_req
  initial begin : mem_model
    int cnt;
    cnt = 0;
    mem_rdy = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clock);
      mem_rdy = 1'b0;
      if (mem_req && reset) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_rdy = 1'b1;
          mem_data = mem_fn(mem_addr);
          req_log.push_back(mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
        if (noise_en && $urandom_range(0, 1) == 1) begin
          mem_rdy = 1'b1;
          mem_data = $urandom;
        end
      end
    end
  end

  // driver: one CPU fetch, returns data, latency in cycles, mem_req cycles seen
  task automatic cpu_fetch(input logic [31:0] a, output logic [31:0] d, output int lat,
                           output int mc, output int rc);
    @(negedge clock);
    if (icache_rdy) @(negedge clock);
    req_log.delete();
    icache_addr = a;
    icache_req = 1'b1;
    lat = -1; mc = 0; rc = 0; d = '0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clock);
      #1;
      if (mem_req) mc++;
      if (icache_rdy) begin
        lat = i; d = icache_data; rc = cyc;
        break;
      end
    end
    icache_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (icache_rdy !== 1'b0) $display("FAIL reset_rdy got %b exp 0", icache_rdy); else passed++;
    checks++; if (icache_data !== 32'h0) $display("FAIL reset_data got %h exp 0", icache_data); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else passed++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_dbg); else passed++;
    reset = 1'b1;
    model_line.delete();
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; int lat, mc, rc;
    cpu_fetch(32'h100, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL cold_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA0) $display("FAIL cold_data got %h exp %h", d, 32'hA0); else passed++;
    checks++; if (req_log.size() != 4) $display("FAIL cold_nreq got %0d exp 4", req_log.size()); else passed++;
    for (int n = 0; n < req_log.size() && n < 4; n++) begin
      checks++;
      if (req_log[n] !== 32'h100 + 4 * n) $display("FAIL cold_addr%0d got %h exp %h", n, req_log[n], 32'h100 + 4 * n);
      else passed++;
    end
    model_fill(32'h100);
  endtask

  task automatic test_hits();
    logic [31:0] d; int lat, mc, rc;
    logic [31:0] addrs [2];
    logic [31:0] exps [2];
    addrs[0] = 32'h104; exps[0] = 32'hA1;
    addrs[1] = 32'h10C; exps[1] = 32'hA3;
    for (int i = 0; i < 2; i++) begin
      cpu_fetch(addrs[i], d, lat, mc, rc);
      checks++; if (lat !== 1) $display("FAIL hit_lat%0d got %0d exp 1", i, lat); else passed++;
      checks++; if (d !== exps[i]) $display("FAIL hit_data%0d got %h exp %h", i, d, exps[i]); else passed++;
      checks++; if (mc !== 0) $display("FAIL hit_memreq%0d got %0d exp 0", i, mc); else passed++;
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int lat, mc, rc;
    cpu_fetch(32'h500, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL conf_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA0) $display("FAIL conf_data got %h exp %h", d, 32'hA0); else passed++;
    checks++; if (req_log.size() != 4 || req_log[0] !== 32'h500 || req_log[3] !== 32'h50C)
                $display("FAIL conf_addrs got n=%0d first=%h exp n=4 first=500 last=50c", req_log.size(), mem_addr);
              else passed++;
    model_fill(32'h500);
    cpu_fetch(32'h100, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL conf_refetch_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA0) $display("FAIL conf_refetch_data got %h exp %h", d, 32'hA0); else passed++;
    model_fill(32'h100);
  endtask

  task automatic test_reset_midrefill();
    logic [31:0] d; int lat, mc, rc; int w;
    @(negedge clock);
    if (icache_rdy) @(negedge clock);
    req_log.delete();
    icache_addr = 32'h300;
    icache_req = 1'b1;
    w = 0;
    while (req_log.size() < 2 && w < 100) begin @(negedge clock); w++; end
    @(negedge clock);
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) $display("FAIL mid_pre_memreq got %b exp 1", mem_req); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL mid_memreq got %b exp 0", mem_req); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL mid_state got %0d exp 0", state_dbg); else passed++;
    icache_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_line.delete();
    cpu_fetch(32'h300, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL mid_refetch_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA0) $display("FAIL mid_refetch_data got %h exp %h", d, 32'hA0); else passed++;
    checks++; if (req_log.size() != 4 || req_log[0] !== 32'h300)
                $display("FAIL mid_refetch_addrs got n=%0d exp n=4 from 300", req_log.size());
              else passed++;
    model_fill(32'h300);
    cpu_fetch(32'h100, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL mid_other_lat got %0d exp 13", lat); else passed++;
    model_fill(32'h100);
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic test_flush_idle();
    logic [31:0] d; int lat, mc, rc;
    cpu_fetch(32'h104, d, lat, mc, rc);
    checks++; if (lat !== 1) $display("FAIL fl_pre_lat got %0d exp 1", lat); else passed++;
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    model_line.delete();
    cpu_fetch(32'h104, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL fl_idle_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA1) $display("FAIL fl_idle_data got %h exp %h", d, 32'hA1); else passed++;
    checks++; if (req_log.size() != 4 || req_log[0] !== 32'h100)
                $display("FAIL fl_idle_addrs got n=%0d exp n=4 from 100", req_log.size());
              else passed++;
    model_fill(32'h104);
  endtask

  task automatic test_flush_refill();
    logic [31:0] d; int lat, mc, rc;
    fork
      cpu_fetch(32'h200, d, lat, mc, rc);
      begin
        repeat (5) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
      end
    join
    checks++; if (lat !== 13) $display("FAIL fl_ref_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA0) $display("FAIL fl_ref_data got %h exp %h", d, 32'hA0); else passed++;
    model_line.delete();
    cpu_fetch(32'h204, d, lat, mc, rc);
    checks++; if (lat !== 13) $display("FAIL fl_after_lat got %0d exp 13", lat); else passed++;
    checks++; if (d !== 32'hA1) $display("FAIL fl_after_data got %h exp %h", d, 32'hA1); else passed++;
    model_fill(32'h204);
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] d; int lat, mc, rc, first_rc;
    logic [31:0] a;
    cpu_fetch(32'h640, d, lat, mc, rc);
    model_fill(32'h640);
    first_rc = 0;
    for (int i = 0; i < 6; i++) begin
      a = 32'h640 + 4 * ((i * 3) % LW);
      cpu_fetch(a, d, lat, mc, rc);
      if (i == 0) first_rc = rc;
      checks++; if (lat !== 1 || d !== mem_fn(a))
                  $display("FAIL b2b_%0d got lat=%0d data=%h exp lat=1 data=%h", i, lat, d, mem_fn(a));
                else passed++;
    end
    checks++; if (rc - first_rc != 10) $display("FAIL b2b_span got %0d exp 10", rc - first_rc); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] d, a, ed; int lat, mc, rc, el, nh, nm, bad;
    logic [23:0] tg;
    logic [3:0] ix;
    bit h;
    directed = 1'b0;
    noise_en = 1'b1;
    nh = 0; nm = 0;
    for (int i = 0; i < 80; i++) begin
      mem_lat = $urandom_range(1, 3);
      tg = ($urandom_range(0, 3) == 3) ? 24'hFFFFFF - 24'($urandom_range(0, 1)) : 24'($urandom_range(0, 2));
      ix = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      a = {tg, ix, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      h = model_hit(a);
      ed = mem_fn({a[31:2], 2'b00});
      el = h ? 1 : miss_lat(mem_lat);
      exp_q.delete();
      if (!h) for (int n = 0; n < LW; n++) exp_q.push_back(line_of(a) * LW * 4 + 4 * n);
      if (h) nh++; else nm++;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      cpu_fetch(a, d, lat, mc, rc);
      checks++; if (lat !== el) $display("FAIL rnd_lat%0d addr=%h got %0d exp %0d", i, a, lat, el); else passed++;
      checks++; if (d !== ed) $display("FAIL rnd_data%0d addr=%h got %h exp %h", i, a, d, ed); else passed++;
      bad = (req_log.size() != exp_q.size()) ? 1 : 0;
      for (int n = 0; n < req_log.size() && n < exp_q.size(); n++)
        if (req_log[n] !== exp_q[n]) bad = 1;
      checks++; if (bad != 0) $display("FAIL rnd_memaddr%0d addr=%h got n=%0d exp n=%0d", i, a, req_log.size(), exp_q.size());
                else passed++;
      model_fill(a);
    end
    checks++; if (nh == 0 || nm == 0) $display("FAIL rnd_mix got hits=%0d misses=%0d exp both nonzero", nh, nm); else passed++;
    noise_en = 1'b0;
    directed = 1'b1;
    mem_lat = 2;
  endtask

  task automatic test_rdy_pulse();
    checks++; if (rdy_viol != 0) $display("FAIL rdy_pulse got %0d double-cycle pulses exp 0", rdy_viol); else passed++;
  endtask

  initial begin
    reset = 1'b0;
    icache_addr = '0;
    icache_req = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_reset_midrefill();
`ifdef ICACHE_FLUSH_EN
    test_flush_idle();
    test_flush_refill();
`endif
    test_back_to_back();
    test_random();
    test_rdy_pulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
